// File: rtl/fdiv_arbiter.sv
// Round-robin arbiter sharing one external combinational fdiv between N_REQ requesters.
// Captures the granted operands, waits LAT cycles for settling, then returns the result.
module fdiv_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LAT   = 2,
    parameter int unsigned W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_data,
    output logic               resp_dz,
    input  logic [N_REQ-1:0]   resp_ready,
    output logic [W-1:0]       div_a,
    output logic [W-1:0]       div_b,
    input  logic [W-1:0]       div_out,
    output logic               busy
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   gnt_q;
    logic [IW-1:0]   gnt_sel;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   next_ptr;
    logic [CW-1:0]   cnt_q;
    logic            dz_q;
    logic            found;
    logic [W-1:0]    sel_b;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found   = 1'b0;
        gnt_sel = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IW'((32'(rr_ptr_q) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_sel = idx;
            end
        end
    end

    assign sel_b    = req_b[gnt_sel*W +: W];
    assign next_ptr = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (found) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StResp;
            StResp:  if (resp_ready[gnt_q]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        busy       = (state_q != StIdle);
        if (state_q == StIdle && found) req_ready[gnt_sel] = 1'b1;
        if (state_q == StResp) resp_valid[gnt_q] = 1'b1;
    end

    // Operands stay on div_a/div_b until the next accept so fdiv does not toggle when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            resp_data <= '0;
            resp_dz   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        div_a <= req_a[gnt_sel*W +: W];
                        div_b <= sel_b;
                        dz_q  <= (sel_b[W-2:0] == '0);
                        gnt_q <= gnt_sel;
                        cnt_q <= CW'(LAT - 1);
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        resp_data <= div_out;
                        resp_dz   <= dz_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StResp: begin
                    if (resp_ready[gnt_q]) rr_ptr_q <= next_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Directed bench for fdiv_arbiter: table of single operations plus hand-written
// sequences for round-robin streaming, backpressure and reset mid-operation.
module tb_fdiv_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned LAT   = 2;
    localparam int unsigned W     = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   resp_valid;
    logic [W-1:0]       resp_data;
    logic               resp_dz;
    logic [N_REQ-1:0]   resp_ready;
    logic [W-1:0]       div_a;
    logic [W-1:0]       div_b;
    wire  [W-1:0]       div_out;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fdiv_arbiter #(.N_REQ(N_REQ), .LAT(LAT), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_dz    (resp_dz),
        .resp_ready (resp_ready),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_out    (div_out),
        .busy       (busy)
    );

    // Stand-in fdiv: known quotients for the operand pairs used here.
    function automatic logic [31:0] fdiv_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h41280000_40A00000: return 32'h40066666;  // 10.5 / 5.0
            64'h3F800000_80000000: return 32'hFF800000;  // 1.0 / -0
            64'h40400000_00000000: return 32'h7F800000;  // 3.0 / +0
            64'h40000000_00000001: return 32'h7F800000;  // 2.0 / min denormal
            64'h40800000_40000000: return 32'h40000000;  // 4.0 / 2.0
            64'hC0C00000_40400000: return 32'hC0000000;  // -6.0 / 3.0
            default:               return 32'h7FC00000;
        endcase
    endfunction

    // Result only settles just before LAT clock periods have passed.
    assign #(LAT*10-1) div_out = fdiv_model(div_a, div_b);

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gnt;
        logic [31:0] q;
        logic        dz;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_lanes(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*W +: W] = sel[i] ? a : 32'h3F800000;
            req_b[i*W +: W] = sel[i] ? b : 32'h3F800000;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid  = '0;
        resp_ready = '0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        int lat;
        @(negedge clk);
        req_valid = v.mask;
        set_lanes(v.gnt, v.a, v.b);
        #1;
        chk("req_ready", 32'(req_ready), 32'(v.gnt));
        chk("busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = '0;
        chk("busy_wait", 32'(busy), 32'd1);
        chk("req_ready_wait", 32'(req_ready), 32'd0);
        chk("div_a", div_a, v.a);
        chk("div_b", div_b, v.b);
        lat = 1;
        while (resp_valid == '0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT + 1));
        chk("resp_valid", 32'(resp_valid), 32'(v.gnt));
        chk("resp_data", resp_data, v.q);
        chk("resp_dz", 32'(resp_dz), 32'(v.dz));
        resp_ready = 4'b1111;
        @(negedge clk);
        resp_ready = '0;
        chk("resp_valid_done", 32'(resp_valid), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        chk("resp_data_kept", resp_data, v.q);
    endtask

    logic [3:0] gr[5];
    int         tc[5];
    int         ngr;
    int         n;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b0001, 32'h41280000, 32'h40A00000, 4'b0001, 32'h40066666, 1'b0};
        vecs[1] = '{4'b0100, 32'h40800000, 32'h40000000, 4'b0100, 32'h40000000, 1'b0};
        vecs[2] = '{4'b0100, 32'h40800000, 32'h40000000, 4'b0100, 32'h40000000, 1'b0};
        vecs[3] = '{4'b1010, 32'h40400000, 32'h00000000, 4'b1000, 32'h7F800000, 1'b1};
        vecs[4] = '{4'b1010, 32'h41280000, 32'h40A00000, 4'b0010, 32'h40066666, 1'b0};
        vecs[5] = '{4'b0011, 32'h3F800000, 32'h80000000, 4'b0001, 32'hFF800000, 1'b1};
        vecs[6] = '{4'b0011, 32'h40000000, 32'h00000001, 4'b0010, 32'h7F800000, 1'b0};
        vecs[7] = '{4'b1111, 32'hC0C00000, 32'h40400000, 4'b0100, 32'hC0000000, 1'b0};

        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        set_lanes(4'b0000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_dz", 32'(resp_dz), 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        rst = 1'b0;

        // Table: pointer carries over between rows (0->1->3->3->0->2->1->2->3).
        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // All four requesters streaming with resp_ready tied high.
        do_reset();
        for (int j = 0; j < 5; j++) begin
            gr[j] = '0;
            tc[j] = 0;
        end
        ngr = 0;
        @(negedge clk);
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        set_lanes(4'b1111, 32'h40800000, 32'h40000000);
        for (int c = 0; c < 40 && ngr < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                gr[ngr] = req_ready;
                tc[ngr] = c;
                ngr++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        for (int j = 0; j < 5; j++) chk("stream_grant", 32'(gr[j]), 32'(1 << (j % 4)));
        for (int j = 1; j < 5; j++) chk("stream_interval", 32'(tc[j] - tc[j-1]), 32'(LAT + 2));
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stream_drain", 32'(busy), 32'd0);

        // Backpressure on requester 1 while everyone else waits.
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        set_lanes(4'b0010, 32'h41280000, 32'h40A00000);
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b1111;
        n = 0;
        while (resp_valid == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'b0010);
            chk("bp_resp_data", resp_data, 32'h40066666);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            resp_ready = 4'b1101;
            @(negedge clk);
        end
        resp_ready = 4'b0010;
        @(negedge clk);
        resp_ready = '0;
        #1;
        chk("bp_released", 32'(resp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        req_valid = '0;
        @(negedge clk);
        chk("withdraw_idle", 32'(busy), 32'd0);

        // Reset while in WAIT with cnt=1, pointer previously at 3.
        do_reset();
        do_op(vecs[1]);
        @(negedge clk);
        req_valid = 4'b1000;
        set_lanes(4'b1000, 32'h41280000, 32'h40A00000);
        #1;
        chk("rw_grant", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        chk("rw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_busy_rst", 32'(busy), 32'd0);
        chk("rw_resp_valid", 32'(resp_valid), 32'd0);
        chk("rw_resp_data", resp_data, 32'd0);
        chk("rw_resp_dz", 32'(resp_dz), 32'd0);
        chk("rw_div_a", div_a, 32'd0);
        chk("rw_div_b", div_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rw_no_resp", 32'(resp_valid), 32'd0);
        end
        req_valid = 4'b1111;
        #1;
        chk("rw_grant_after", 32'(req_ready), 32'b0001);
        req_valid = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
